hms_timer_ex: RTL and testbench

//  Parametrised hour:minute:second timer, successor of the basic timer block.

---
 rtl/hms_timer_pkg.sv | 14 +
 rtl/hms_timer_ex_tick_prescaler.sv | 27 ++
 rtl/hms_timer_ex.sv | 178 +++++++++++++++++
 tb/tb_hms_timer_ex.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/hms_timer_pkg.sv
// Shared types and field limits for the H:M:S timer.
package hms_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

endpackage

// File: rtl/hms_timer_ex_tick_prescaler.sv
// Divides clk down to a one-cycle tick strobe every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic cut_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // A 1-bit counter keeps TICK_DIV=1 legal; the compare then always hits.
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count enabled cycles, wrap on the tick, hold while disabled.
  always_ff @(posedge clk or negedge cut_n) begin
    if (!cut_n)     cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (en)    cnt <= tick ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/hms_timer_ex.sv
// Hour:minute:second timer with prescaler, pause, auto-reload and range check.
//
// state | meaning
// IDLE  | set value loaded or reset, waiting for start
// RUN   | counting on each tick
// PAUSE | counting frozen while pause is high
// DONE  | terminal value reached (one-shot), value held
module hms_timer_ex
  import hms_timer_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TICK_DIV = 50000000,
  parameter int MAX_HOUR = 99
) (
  input  logic             clk,
  input  logic             cut_n,
  input  logic             write,
  input  logic             up,
  input  logic             reload,
  input  logic [WIDTH-1:0] insec,
  input  logic [WIDTH-1:0] inmin,
  input  logic [WIDTH-1:0] inhour,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] sec,
  output logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] hour,
  output logic             alarm,
  output logic             busy_n,
  output logic             err
);

  localparam logic [WIDTH-1:0] S_MAX = WIDTH'(SEC_MAX);
  localparam logic [WIDTH-1:0] M_MAX = WIDTH'(MIN_MAX);
  localparam logic [WIDTH-1:0] H_MAX = WIDTH'(MAX_HOUR);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] set_s, set_m, set_h;
  logic             up_r, reload_r;
  logic             pend;        // reload armed: next tick restarts the period
  logic             tick, en, clr;
  logic             in_valid, set_zero, idle_like, start_go, at_term;
  logic [WIDTH-1:0] nx_s, nx_m, nx_h;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign in_valid  = (insec <= S_MAX) && (inmin <= M_MAX) && (inhour <= H_MAX);
  assign set_zero  = (set_s == '0) && (set_m == '0) && (set_h == '0);
  assign start_go  = idle_like && !write && start && !set_zero;
  // Enabled in PAUSE too once pause drops, so a pause costs exactly its own length.
  assign en        = ((state == RUN) || (state == PAUSE)) && !pause;
  assign clr       = start_go;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk   (clk),
    .cut_n (cut_n),
    .en    (en),
    .clr   (clr),
    .tick  (tick)
  );

  // Next counter value one tick away, per-field with carry/borrow.
  always_comb begin
    nx_s = sec;
    nx_m = min;
    nx_h = hour;
    if (up_r) begin
      if (sec == S_MAX) begin
        nx_s = '0;
        if (min == M_MAX) begin
          nx_m = '0;
          nx_h = (hour == H_MAX) ? '0 : hour + ONE;
        end else begin
          nx_m = min + ONE;
        end
      end else begin
        nx_s = sec + ONE;
      end
    end else begin
      if (sec == '0) begin
        nx_s = S_MAX;
        if (min == '0) begin
          nx_m = M_MAX;
          nx_h = (hour == '0) ? H_MAX : hour - ONE;
        end else begin
          nx_m = min - ONE;
        end
      end else begin
        nx_s = sec - ONE;
      end
    end
  end

  assign at_term = up_r ? ((nx_s == set_s) && (nx_m == set_m) && (nx_h == set_h))
                        : ((nx_s == '0) && (nx_m == '0) && (nx_h == '0));

  // Control FSM, set/count registers and pulse outputs.
  always_ff @(posedge clk or negedge cut_n) begin
    if (!cut_n) begin
      state    <= IDLE;
      sec      <= '0;
      min      <= '0;
      hour     <= '0;
      set_s    <= '0;
      set_m    <= '0;
      set_h    <= '0;
      up_r     <= 1'b0;
      reload_r <= 1'b0;
      pend     <= 1'b0;
      alarm    <= 1'b0;
      err      <= 1'b0;
      busy_n   <= 1'b1;
    end else begin
      alarm <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (write) begin
            if (in_valid) begin
              set_s    <= insec;
              set_m    <= inmin;
              set_h    <= inhour;
              up_r     <= up;
              reload_r <= reload;
              sec      <= up ? '0 : insec;
              min      <= up ? '0 : inmin;
              hour     <= up ? '0 : inhour;
              state    <= IDLE;
            end else begin
              err <= 1'b1;
            end
          end else if (start) begin
            if (set_zero) begin
              err <= 1'b1;
            end else begin
              state  <= RUN;
              busy_n <= 1'b0;
              pend   <= 1'b0;
              sec    <= up_r ? '0 : set_s;
              min    <= up_r ? '0 : set_m;
              hour   <= up_r ? '0 : set_h;
            end
          end
        end
        RUN, PAUSE: begin
          if (pause) begin
            state <= PAUSE;
          end else begin
            state <= RUN;
            if (tick) begin
              if (pend) begin
                pend <= 1'b0;
                sec  <= up_r ? '0 : set_s;
                min  <= up_r ? '0 : set_m;
                hour <= up_r ? '0 : set_h;
              end else begin
                sec  <= nx_s;
                min  <= nx_m;
                hour <= nx_h;
                if (at_term) begin
                  alarm <= 1'b1;
                  if (reload_r) begin
                    pend <= 1'b1;
                  end else begin
                    state  <= DONE;
                    busy_n <= 1'b1;
                  end
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hms_timer_ex.sv
// Directed plus random test of hms_timer_ex against a total-seconds model.
module tb_hms_timer_ex;

  localparam int WIDTH    = 16;
  localparam int TICK_DIV = 3;
  localparam int MAX_HOUR = 99;

  logic             clk = 1'b0;
  logic             cut_n, write, up, reload, start, pause;
  logic [WIDTH-1:0] insec, inmin, inhour;
  logic [WIDTH-1:0] sec, min, hour;
  logic             alarm, busy_n, err;

  int vectors = 0;
  int miscompares = 0;

  hms_timer_ex #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .MAX_HOUR(MAX_HOUR)) dut (
    .clk    (clk),
    .cut_n  (cut_n),
    .write  (write),
    .up     (up),
    .reload (reload),
    .insec  (insec),
    .inmin  (inmin),
    .inhour (inhour),
    .start  (start),
    .pause  (pause),
    .sec    (sec),
    .min    (min),
    .hour   (hour),
    .alarm  (alarm),
    .busy_n (busy_n),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Reference model: the counter is one number of seconds, the mode is a small int.
  // m_mode: 0 idle, 1 running, 2 paused, 3 done
  int m_mode, m_set, m_cnt, m_pre;
  bit m_up, m_rel, m_pend, m_alarm, m_err;

  function automatic void model_reset();
    m_mode = 0; m_set = 0; m_cnt = 0; m_pre = 0;
    m_up = 0; m_rel = 0; m_pend = 0; m_alarm = 0; m_err = 0;
  endfunction

  function automatic int start_val();
    return m_up ? 0 : m_set;
  endfunction

  function automatic void model_step();
    bit t;
    int s, mi, h;
    m_alarm = 0;
    m_err   = 0;
    s = int'(insec); mi = int'(inmin); h = int'(inhour);
    if (m_mode == 0 || m_mode == 3) begin
      if (write) begin
        if (s <= 59 && mi <= 59 && h <= MAX_HOUR) begin
          m_set  = h * 3600 + mi * 60 + s;
          m_up   = up;
          m_rel  = reload;
          m_cnt  = start_val();
          m_mode = 0;
        end else begin
          m_err = 1;
        end
      end else if (start) begin
        if (m_set == 0) m_err = 1;
        else begin
          m_mode = 1; m_pre = 0; m_pend = 0; m_cnt = start_val();
        end
      end
    end else begin
      if (pause) m_mode = 2;
      else begin
        m_mode = 1;
        t = (m_pre == TICK_DIV - 1);
        m_pre = t ? 0 : m_pre + 1;
        if (t) begin
          if (m_pend) begin
            m_cnt = start_val(); m_pend = 0;
          end else begin
            m_cnt = m_up ? m_cnt + 1 : m_cnt - 1;
            if (m_cnt == (m_up ? m_set : 0)) begin
              m_alarm = 1;
              if (m_rel) m_pend = 1;
              else m_mode = 3;
            end
          end
        end
      end
    end
  endfunction

  task automatic check(input string tag);
    logic [3*WIDTH+2:0] obs, expv;
    obs  = {sec, min, hour, alarm, busy_n, err};
    expv = {WIDTH'(m_cnt % 60), WIDTH'((m_cnt / 60) % 60), WIDTH'(m_cnt / 3600),
            m_alarm, !(m_mode == 1 || m_mode == 2), m_err};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check(tag);
  endtask

  task automatic do_write(input int s, input int mi, input int h, input bit u, input bit r);
    insec = WIDTH'(s); inmin = WIDTH'(mi); inhour = WIDTH'(h);
    up = u; reload = r; write = 1'b1;
    cyc("write");
    write = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc("start");
    start = 1'b0;
  endtask

  task automatic wait_alarm(input int budget, output int n);
    n = 0;
    do begin
      cyc("run");
      n++;
    end while (alarm !== 1'b1 && n < budget);
  endtask

  task automatic expect_int(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic async_cut();
    #2;
    cut_n = 1'b0;
    model_reset();
    #1;
    check("cut_async");
    cyc("cut_hold");
    cut_n = 1'b1;
    cyc("cut_release");
  endtask

  initial begin
    int n, tot;
    cut_n = 1'b0; write = 0; up = 0; reload = 0; start = 0; pause = 0;
    insec = '0; inmin = '0; inhour = '0;
    model_reset();
    #12;
    check("reset");
    cut_n = 1'b1;
    cyc("idle"); cyc("idle");

    // Down count 0:1:5, 65 ticks
    do_write(5, 1, 0, 0, 0);
    do_start();
    wait_alarm(400, n);
    expect_int("down65_cycles", n, 65 * TICK_DIV);
    repeat (3) cyc("done_hold");

    // Up count to 1:0:0 through the hour carry
    do_write(0, 0, 1, 1, 0);
    do_start();
    wait_alarm(3700 * TICK_DIV, n);
    expect_int("up3600_cycles", n, 3600 * TICK_DIV);
    cyc("done_hold");

    // Mid-run write ignored, then async abort
    do_write(9, 0, 0, 0, 0);
    do_start();
    repeat (5) cyc("run");
    do_write(9, 0, 0, 1, 1);
    repeat (5) cyc("run");
    async_cut();
    repeat (30) cyc("after_cut");

    // Invalid write and zero start
    do_write(60, 0, 0, 0, 0);
    expect_int("err_bad_sec", int'(err), 1);
    cyc("err_clear");
    do_write(0, 0, MAX_HOUR + 1, 0, 0);
    do_start();
    expect_int("err_zero_start", int'(err), 1);
    cyc("idle");

    // Periodic down count 0:0:3
    do_write(3, 0, 0, 0, 1);
    do_start();
    wait_alarm(100, n);
    expect_int("reload_first", n, 3 * TICK_DIV);
    for (int k = 0; k < 3; k++) begin
      wait_alarm(100, n);
      expect_int("reload_period", n, 4 * TICK_DIV);
    end
    async_cut();

    // Pause held 10 clocks
    do_write(5, 1, 0, 0, 0);
    do_start();
    tot = 0;
    repeat (31) begin cyc("run"); tot++; end
    pause = 1'b1;
    repeat (10) begin cyc("paused"); tot++; end
    pause = 1'b0;
    wait_alarm(400, n);
    expect_int("pause_delay", tot + n, 65 * TICK_DIV + 10);

    // Random traffic
    for (int i = 0; i < 5000; i++) begin
      write = ($urandom_range(0, 29) == 0);
      start = ($urandom_range(0, 19) == 0);
      pause = ($urandom_range(0, 9) == 0);
      up    = $urandom_range(0, 1);
      reload = $urandom_range(0, 1);
      insec = WIDTH'($urandom_range(0, 62));
      inmin = WIDTH'($urandom_range(0, 1));
      inhour = ($urandom_range(0, 9) == 0) ? WIDTH'(MAX_HOUR + 1) : '0;
      cyc("random");
    end
    write = 0; start = 0; pause = 0;
    cyc("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
